// File: rtl/apes_dac_pkg.sv
// Shared definitions for the multi-channel APES DAC serial interface:
// FSM encoding, dac_reg field map and the channel field of register writes.
package apes_dac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } dac_state_e;

  localparam int REG_BUSY_BIT = 31;
  localparam int REG_CH_LSB   = 24;
  localparam int REG_CH_W     = 4;
  localparam int REG_PEND_LSB = 16;
  localparam int REG_PEND_W   = 8;
  localparam int REG_DATA_LSB = 0;
  localparam int REG_DATA_W   = 16;

  // Channel number carried in Lcld[15:12] of a register write
  localparam int CH_FIELD_LSB = 12;
  localparam int CH_FIELD_W   = 4;

  typedef logic [CH_FIELD_W-1:0] ch_idx_t;

endpackage

// File: rtl/apes_rr_arb.sv
// Combinational round-robin picker: returns the first requesting index after
// 'last', wrapping at N-1; valid is low when nothing requests.
module apes_rr_arb
  import apes_dac_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  ch_idx_t      last,
  output ch_idx_t      grant,
  output logic         valid
);

  int idx;

  always_comb begin
    grant = last;
    valid = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N; i++) begin
      idx = int'(last) + i;
      if (idx >= N) idx = idx - N;
      if (!valid && req[idx]) begin
        valid = 1'b1;
        grant = ch_idx_t'(idx);
      end
    end
  end

endmodule

// File: rtl/apes_dac_mux.sv
// Multi-channel APES DAC serial interface: shared Dac_clk/Dac_dat, one CTRL_ENn per
// channel, round-robin service of pending words. Optional ldac_n under APES_DAC_MUX_LDAC_EN.
module apes_dac_mux
  import apes_dac_pkg::*;
#(
  parameter int         NUM_CH   = 4,
  parameter int         DATA_W   = 12,
  parameter int         FRAME_W  = 16,
  parameter int         DIV_LOG2 = 5,
  parameter logic [8:0] REG_ADDR = 9'h008
) (
  input  logic              clk50,
  input  logic              rst,
  input  logic              dac_rst,
  input  logic              regw_pls,
  input  logic [8:0]        Lcla,
  input  logic [31:0]       Lcld,
  output logic              Dac_clk,
  output logic              Dac_dat,
  output logic [NUM_CH-1:0] CTRL_ENn,
  output logic              busy,
  output logic [31:0]       dac_reg,
`ifdef APES_DAC_MUX_LDAC_EN
  output logic              ldac_n,
`endif
  output dac_state_e        state_dbg
);

  localparam logic [5:0] LAST_BIT = 6'(FRAME_W - 1);

  logic [DIV_LOG2:0]  div;
  logic               tick;
  dac_state_e         state, state_n;
  logic [NUM_CH-1:0]  pend;
  logic [DATA_W-1:0]  pend_data [NUM_CH];
  logic [FRAME_W-1:0] shift;
  logic [5:0]         bitcnt;
  ch_idx_t            last_ch, act_ch, arb_grant, wr_ch;
  logic               arb_valid, wr_acc, load, frame_end;
  logic [DATA_W-1:0]  wr_val, sel_data, act_data, done_data;
  logic               lcld_unused;

  assign Dac_clk     = div[DIV_LOG2];
  assign tick        = (div == {1'b0, {DIV_LOG2{1'b1}}});
  assign wr_ch       = Lcld[CH_FIELD_LSB +: CH_FIELD_W];
  assign wr_val      = Lcld[DATA_W-1:0];
  assign wr_acc      = regw_pls && (Lcla == REG_ADDR) && (32'(wr_ch) < NUM_CH) && !dac_rst;
  assign lcld_unused = ^Lcld;
  assign state_dbg   = state;

  apes_rr_arb #(.N(NUM_CH)) u_arb (
    .req   (pend),
    .last  (last_ch),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  // A write landing on the channel being picked this cycle is what gets shifted out
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx_t'(i) == arb_grant) sel_data = pend_data[i];
    end
    if (wr_acc && (wr_ch == arb_grant)) sel_data = wr_val;
  end

  always_ff @(posedge clk50) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // The GAP tick may start the next frame directly, keeping the inter-frame
  // gap at exactly one Dac_clk period; new frames are held off during dac_rst.
  always_comb begin
    state_n   = state;
    load      = 1'b0;
    frame_end = 1'b0;
    if (tick) begin
      case (state)
        ST_IDLE: begin
          if (arb_valid && !dac_rst) begin
            load    = 1'b1;
            state_n = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bitcnt == LAST_BIT) begin
            frame_end = 1'b1;
            state_n   = ST_GAP;
          end
        end
        ST_GAP: begin
`ifdef APES_DAC_MUX_LDAC_EN
          if (ldac_n && (pend == '0)) state_n = ST_GAP;
          else
`endif
          if (arb_valid && !dac_rst) begin
            load    = 1'b1;
            state_n = ST_SHIFT;
          end else begin
            state_n = ST_IDLE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      pend <= '1;
      for (int i = 0; i < NUM_CH; i++) pend_data[i] <= '0;
    end else if (dac_rst) begin
      pend <= '1;
      for (int i = 0; i < NUM_CH; i++) pend_data[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (load && (ch_idx_t'(i) == arb_grant)) begin
          pend[i] <= 1'b0;
        end else if (wr_acc && (ch_idx_t'(i) == wr_ch)) begin
          pend[i]      <= 1'b1;
          pend_data[i] <= wr_val;
        end
      end
    end
  end

  // last_ch steers arbitration; act_ch is the channel shown in dac_reg
  always_ff @(posedge clk50) begin
    if (rst) begin
      div       <= '0;
      shift     <= '0;
      bitcnt    <= '0;
      CTRL_ENn  <= '1;
      last_ch   <= ch_idx_t'(NUM_CH - 1);
      act_ch    <= '0;
      act_data  <= '0;
      done_data <= '0;
    end else begin
      div <= div + 1'b1;
      if (load) begin
        shift    <= FRAME_W'(sel_data);
        act_data <= sel_data;
        bitcnt   <= '0;
        act_ch   <= arb_grant;
        for (int i = 0; i < NUM_CH; i++) CTRL_ENn[i] <= (ch_idx_t'(i) != arb_grant);
      end else if (frame_end) begin
        CTRL_ENn  <= '1;
        last_ch   <= act_ch;
        done_data <= act_data;
      end else if (tick && (state == ST_SHIFT)) begin
        shift  <= {shift[FRAME_W-2:0], 1'b0};
        bitcnt <= bitcnt + 1'b1;
      end
    end
  end

`ifdef APES_DAC_MUX_LDAC_EN
  // Low for the extra GAP period after a frame that leaves nothing pending
  always_ff @(posedge clk50) begin
    if (rst)                            ldac_n <= 1'b1;
    else if (tick && (state == ST_GAP)) ldac_n <= !(ldac_n && (pend == '0));
  end
`endif

  assign Dac_dat = (state == ST_SHIFT) && shift[FRAME_W-1];
  assign busy    = (state != ST_IDLE) || (|pend);

  always_comb begin
    dac_reg                                = '0;
    dac_reg[REG_BUSY_BIT]                  = busy;
    dac_reg[REG_CH_LSB +: REG_CH_W]        = act_ch;
    dac_reg[REG_PEND_LSB +: REG_PEND_W]    = REG_PEND_W'(pend);
    dac_reg[REG_DATA_LSB +: REG_DATA_W]    = REG_DATA_W'(done_data);
  end

endmodule

// File: tb/tb_apes_dac_mux.sv
// Bench for apes_dac_mux: frame monitor on Dac_clk rises, vector table,
// hand-written corner sequences and randomized write batches against a frame-level model.
module tb_apes_dac_mux;
  import apes_dac_pkg::*;

  localparam int NUM_CH  = 4;
  localparam int DATA_W  = 12;
  localparam int FRAME_W = 16;

  logic              clk50 = 1'b0;
  logic              rst, dac_rst, regw_pls;
  logic [8:0]        Lcla;
  logic [31:0]       Lcld;
  logic              Dac_clk, Dac_dat, busy;
  logic [NUM_CH-1:0] CTRL_ENn;
  logic [31:0]       dac_reg;
  dac_state_e        state_dbg;
`ifdef APES_DAC_MUX_LDAC_EN
  logic              ldac_n;
`endif

  apes_dac_mux #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FRAME_W(FRAME_W), .DIV_LOG2(5), .REG_ADDR(9'h008)
  ) dut (
    .clk50    (clk50),
    .rst      (rst),
    .dac_rst  (dac_rst),
    .regw_pls (regw_pls),
    .Lcla     (Lcla),
    .Lcld     (Lcld),
    .Dac_clk  (Dac_clk),
    .Dac_dat  (Dac_dat),
    .CTRL_ENn (CTRL_ENn),
    .busy     (busy),
    .dac_reg  (dac_reg),
`ifdef APES_DAC_MUX_LDAC_EN
    .ldac_n   (ldac_n),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #10 clk50 = ~clk50;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [19:0] exp_q[$];
  logic [19:0] got_q[$];
  int          gap_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_frames(input string name);
    int n;
    check({name, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({name, "_frame"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- frame monitor ----------------
  // Samples at the clk50 falling edge following each Dac_clk rise.
  initial begin
    logic       dclk_q;
    logic       in_frame;
    logic [3:0] f_ch;
    logic [31:0] f_data;
    int         f_bits, gap_cnt, n_low, c;
    dclk_q = 1'b0; in_frame = 1'b0; f_ch = '0; f_data = '0; f_bits = 0; gap_cnt = 0;
    forever begin
      @(negedge clk50);
      if (rst) begin
        dclk_q = 1'b0; in_frame = 1'b0; gap_cnt = 0;
      end else begin
        if (Dac_clk && !dclk_q) begin
          n_low = 0; c = 0;
          for (int i = 0; i < NUM_CH; i++) if (!CTRL_ENn[i]) begin n_low++; c = i; end
          if (n_low > 1) check("enable_onehot", n_low, 1);
          if (n_low == 1) begin
            if (!in_frame) begin
              in_frame = 1'b1; f_ch = 4'(c); f_data = '0; f_bits = 0;
              gap_q.push_back(gap_cnt);
            end else if (4'(c) != f_ch) begin
              check("enable_switch", c, f_ch);
            end
            f_data = {f_data[30:0], Dac_dat};
            f_bits++;
          end else if (in_frame) begin
            in_frame = 1'b0;
            check("frame_len", f_bits, FRAME_W);
            got_q.push_back({f_ch, f_data[15:0]});
            gap_cnt = 1;
          end else begin
            gap_cnt++;
          end
        end
        dclk_q = Dac_clk;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk50);
  endtask

  task automatic wait_rise();
    logic p;
    int   n;
    p = Dac_clk;
    n = 0;
    while (n < 200) begin
      @(negedge clk50);
      if (Dac_clk && !p) break;
      p = Dac_clk;
      n++;
    end
    if (n >= 200) check("rise_timeout", 0, 1);
  endtask

  task automatic reg_write(input logic [8:0] addr, input logic [31:0] data);
    regw_pls = 1'b1; Lcla = addr; Lcld = data;
    @(negedge clk50);
    regw_pls = 1'b0; Lcla = '0; Lcld = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 20000) begin
      @(negedge clk50);
      n++;
    end
    if (n >= 20000) check("idle_timeout", busy, 0);
    cyc(4);
  endtask

  // ---------------- vectors and model ----------------
  typedef struct {
    logic [8:0]  addr;
    logic [31:0] data;
    logic        has_frame;
    logic [3:0]  ch;
    logic [15:0] val;
    logic [31:0] reg_exp;
  } vec_t;

  vec_t        vecs[8];
  logic [11:0] m_val[NUM_CH];
  logic        m_pend[NUM_CH];
  int          model_last;
  logic [31:0] exp_reg;

  initial begin
    rst = 1'b1; dac_rst = 1'b0; regw_pls = 1'b0; Lcla = '0; Lcld = '0;
    vecs[0] = '{9'h008, 32'h0000_3FFF, 1'b1, 4'd3, 16'h0FFF, 32'h0300_0FFF};
    vecs[1] = '{9'h008, 32'h0000_4555, 1'b0, 4'd0, 16'h0000, 32'h0300_0FFF};
    vecs[2] = '{9'h009, 32'h0000_2123, 1'b0, 4'd0, 16'h0000, 32'h0300_0FFF};
    vecs[3] = '{9'h008, 32'hFFFF_0800, 1'b1, 4'd0, 16'h0800, 32'h0000_0800};
    vecs[4] = '{9'h008, 32'h0000_7001, 1'b0, 4'd0, 16'h0000, 32'h0000_0800};
    vecs[5] = '{9'h008, 32'h0000_2001, 1'b1, 4'd2, 16'h0001, 32'h0200_0001};
    vecs[6] = '{9'h008, 32'h0000_5ABC, 1'b0, 4'd0, 16'h0000, 32'h0200_0001};
    vecs[7] = '{9'h008, 32'h0000_1ABC, 1'b1, 4'd1, 16'h0ABC, 32'h0100_0ABC};

    // reset state
    cyc(5);
    check("rst_dac_clk", Dac_clk, 0);
    check("rst_dac_dat", Dac_dat, 0);
    check("rst_enn", CTRL_ENn, 4'hF);
    check("rst_busy", busy, 1);
    check("rst_dac_reg", dac_reg, 32'h800F_0000);
    rst = 1'b0;

    // power-on zero frames ch0..ch3, one-period gaps
    for (int c = 0; c < NUM_CH; c++) exp_q.push_back({4'(c), 16'h0000});
    wait_idle();
    if (gap_q.size() >= 4) for (int i = 1; i < 4; i++) check("init_gap", gap_q[i], 1);
    else check("init_gap_count", gap_q.size(), 4);
    gap_q.delete();
    check_frames("init");
    check("init_reg", dac_reg, 32'h0300_0000);
    model_last = 3;

    // single-write vector table
    for (int v = 0; v < 8; v++) begin
      wait_rise();
      reg_write(vecs[v].addr, vecs[v].data);
      if (vecs[v].has_frame) begin
        exp_q.push_back({vecs[v].ch, vecs[v].val});
        model_last = int'(vecs[v].ch);
      end else begin
        cyc(1500);
      end
      wait_idle();
      check_frames("vec");
      check("vec_reg", dac_reg, vecs[v].reg_exp);
    end

    // three writes in one idle window, last served ch1 -> order 3,0,1
    wait_rise();
    reg_write(9'h008, 32'h0000_0011);
    reg_write(9'h008, 32'h0000_3033);
    reg_write(9'h008, 32'h0000_1022);
    exp_q.push_back({4'd3, 16'h0033});
    exp_q.push_back({4'd0, 16'h0011});
    exp_q.push_back({4'd1, 16'h0022});
    wait_idle();
    check_frames("rr_order");
    check("rr_reg", dac_reg, 32'h0100_0022);

    // overwrite before service: last wins, single frame
    wait_rise();
    reg_write(9'h008, 32'h0000_2111);
    reg_write(9'h008, 32'h0000_2222);
    exp_q.push_back({4'd2, 16'h0222});
    wait_idle();
    check_frames("overwrite");
    check("overwrite_reg", dac_reg, 32'h0200_0222);

    // dac_rst mid-frame on ch2
    wait_rise();
    reg_write(9'h008, 32'h0000_25A5);
    begin
      int n;
      n = 0;
      while (CTRL_ENn[2] !== 1'b0 && n < 300) begin @(negedge clk50); n++; end
      if (n >= 300) check("dacrst_start_timeout", CTRL_ENn, 4'hB);
    end
    repeat (5) wait_rise();
    dac_rst = 1'b1;
    reg_write(9'h008, 32'h0000_0123);
    reg_write(9'h008, 32'h0000_3456);
    cyc(1500);
    check("dacrst_reg", dac_reg, 32'h820F_05A5);
    check("dacrst_enn", CTRL_ENn, 4'hF);
    dac_rst = 1'b0;
    exp_q.push_back({4'd2, 16'h05A5});
    exp_q.push_back({4'd3, 16'h0000});
    exp_q.push_back({4'd0, 16'h0000});
    exp_q.push_back({4'd1, 16'h0000});
    exp_q.push_back({4'd2, 16'h0000});
    wait_idle();
    check_frames("dacrst");
    check("dacrst_end_reg", dac_reg, 32'h0200_0000);
    model_last = 2;
    exp_reg = 32'h0200_0000;

    // randomized write batches against the frame-level model
    for (int b = 0; b < 6; b++) begin
      int k, ch, c, served;
      logic [8:0]  addr;
      logic [31:0] data;
      for (int i = 0; i < NUM_CH; i++) begin m_pend[i] = 1'b0; m_val[i] = '0; end
      k = $urandom_range(1, 4);
      wait_rise();
      for (int w = 0; w < k; w++) begin
        ch   = $urandom_range(0, 5);
        addr = ($urandom_range(0, 3) == 0) ? 9'h00C : 9'h008;
        data = $urandom;
        data[15:12] = 4'(ch);
        reg_write(addr, data);
        if (addr == 9'h008 && ch < NUM_CH) begin
          m_pend[ch] = 1'b1;
          m_val[ch]  = data[11:0];
        end
      end
      served = model_last;
      for (int i = 1; i <= NUM_CH; i++) begin
        c = (model_last + i) % NUM_CH;
        if (m_pend[c]) begin
          exp_q.push_back({4'(c), 4'h0, m_val[c]});
          exp_reg = {8'(c), 8'h00, 4'h0, m_val[c]};
          served = c;
        end
      end
      model_last = served;
      if (exp_q.size() == 0) cyc(1500);
      wait_idle();
      check_frames("rand");
      check("rand_reg", dac_reg, exp_reg);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
